// File: rtl/narnet_pkg.sv
// rtl/narnet_pkg.sv - shared state encoding and defaults for the NARX feeder
package narnet_pkg;

  localparam int N_DEF = 10;
  localparam int Q_DEF = 8;

  localparam logic signed [9:0] K_0P375_Q8 = 10'sd96;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NNRST,
    ST_ACCEPT,
    ST_ISSUE,
    ST_WAIT,
    ST_PUSH,
    ST_FIN
  } state_t;

  // A zero prime length still needs one seed to start the feedback chain.
  function automatic logic [4:0] eff_prime(input logic [4:0] p);
    return (p == 5'd0) ? 5'd1 : p;
  endfunction

endpackage

// File: rtl/narnet_out_fifo.sv
// rtl/narnet_out_fifo.sv - synchronous prediction FIFO with full/empty/count
module narnet_out_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/narnet_feeder.sv
// rtl/narnet_feeder.sv - primes a NARX network with seeds, then feeds its output back
module narnet_feeder
  import narnet_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int Q          = Q_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [4:0]   prime_len,
  input  logic [7:0]   horizon,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic         nn_rst,
  output logic         nn_enable,
  output logic [N-1:0] nn_x,
  output logic         nn_x_ready,
  input  logic [N-1:0] nn_y,
  input  logic         nn_out_ready,
  output logic         m_valid,
  output logic [N-1:0] m_data,
  input  logic         m_ready,
  output logic         busy,
  output logic         done,
  output logic         timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  if (Q > N) begin : g_q_check
    $error("Q must not exceed N");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two");
  end

  state_t state, next;

  logic [N-1:0]   y_q;
  logic [4:0]     prime_q;
  logic [4:0]     seed_cnt;
  logic [7:0]     rem;
  logic [WD_W-1:0] wd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE:   if (start) next = ST_NNRST;
      ST_NNRST:  next = ST_ACCEPT;
      ST_ACCEPT: if (s_valid) next = ST_ISSUE;
      ST_ISSUE:  next = ST_WAIT;
      ST_WAIT: begin
        if (nn_out_ready) begin
          if (seed_cnt != prime_q) next = ST_ACCEPT;
          else if (rem != 8'd0)    next = ST_PUSH;
          else                     next = ST_FIN;
        end else if (wd == WD_LAST) begin
          next = ST_FIN;
        end
      end
      ST_PUSH:   if (!fifo_full) next = (rem == 8'd1) ? ST_FIN : ST_ISSUE;
      ST_FIN:    next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready    = 1'b0;
    nn_rst     = 1'b0;
    nn_x_ready = 1'b0;
    done       = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_NNRST:  nn_rst     = 1'b1;
      ST_ACCEPT: s_ready    = 1'b1;
      ST_ISSUE:  nn_x_ready = 1'b1;
      ST_FIN:    done       = 1'b1;
      default:   ;
    endcase
  end

  // Full is the registered occupancy, so a pop in the same cycle cannot free the slot.
  assign fifo_push = (state == ST_PUSH) && !fifo_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nn_x        <= '0;
      y_q         <= '0;
      prime_q     <= '0;
      seed_cnt    <= '0;
      rem         <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
      nn_enable   <= 1'b0;
    end else begin
      nn_enable <= 1'b1;
      case (state)
        ST_IDLE: if (start) begin
          prime_q     <= eff_prime(prime_len);
          rem         <= horizon;
          seed_cnt    <= '0;
          timeout_err <= 1'b0;
        end
        ST_ACCEPT: if (s_valid) begin
          nn_x     <= s_data;
          seed_cnt <= seed_cnt + 5'd1;
        end
        ST_ISSUE: wd <= '0;
        ST_WAIT: begin
          wd <= wd + 1'b1;
          if (nn_out_ready)       y_q         <= nn_y;
          else if (wd == WD_LAST) timeout_err <= 1'b1;
        end
        ST_PUSH: if (!fifo_full) begin
          rem  <= rem - 8'd1;
          nn_x <= y_q;
        end
        default: ;
      endcase
    end
  end

  narnet_out_fifo #(
    .W     (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_push),
    .wr_data (y_q),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  assign m_valid = !fifo_empty;

endmodule
